instruction_cache: RTL and testbench

- Direct-mapped, read-only instruction cache placed directly downstream of the program counter.
- Takes the current PC, returns the 32-bit instruction to the decode/register stage, and drives the PC-stall "busy" line on a miss.
- On a miss it fetches a 16-byte block from the multi-cycle instruction memory.

---
 rtl/instruction_cache_if.sv | 21 ++
 rtl/instruction_cache.sv | 62 ++++++
 tb/tb_instruction_cache.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_if.sv
// instruction_cache_if: fetch-side and instruction-memory-side signals of the instruction cache.
interface instruction_cache_if #(
    parameter int MA_W = 6,
    parameter int LINE_W = 128
);
    logic [31:0] pc;
    logic [31:0] instruction;
    logic busywait;
    logic [MA_W-1:0] mem_address;
    logic mem_read;
    logic [LINE_W-1:0] mem_readdata;
    logic mem_busywait;
    modport slave (
        input pc, mem_readdata, mem_busywait,
        output instruction, busywait, mem_address, mem_read
    );
    modport master (
        output pc, mem_readdata, mem_busywait,
        input instruction, busywait, mem_address, mem_read
    );
endinterface

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only cache between the PC and a multi-cycle instruction memory.
module instruction_cache #(
    parameter int BLOCKS = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int TAG_W = 3
) (
    input logic CLK,
    input logic RESET,
    instruction_cache_if.slave bus
);
    localparam int IDX_W = $clog2(BLOCKS);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int LINE_W = 32 * WORDS_PER_BLOCK;
    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;
    state_t state_q;
    logic [BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [BLOCKS];
    logic [LINE_W-1:0] data_q [BLOCKS];
    logic [TAG_W+IDX_W-1:0] addr_q;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic hit;
    logic miss;
    assign off = bus.pc[2 +: OFF_W];
    assign idx = bus.pc[2+OFF_W +: IDX_W];
    assign tag = bus.pc[2+OFF_W+IDX_W +: TAG_W];
    // pc[31] marks the PC's pre-boot value; no lookup is made for it.
    assign hit = !bus.pc[31] && valid_q[idx] && tag_q[idx] == tag;
    assign miss = !RESET && !bus.pc[31] && !hit;
    assign bus.busywait = state_q != IDLE || miss;
    assign bus.instruction = (state_q == IDLE && hit) ? data_q[idx][32*off +: 32] : '0;
    assign bus.mem_read = state_q == MEM_READ;
    assign bus.mem_address = addr_q;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (miss) begin
                    state_q <= MEM_READ;
                    addr_q <= {tag, idx};
                end
                MEM_READ: if (!bus.mem_busywait) state_q <= UPDATE;
                UPDATE: begin
                    state_q <= IDLE;
                    valid_q[addr_q[IDX_W-1:0]] <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // Line payload needs no reset; the valid bits alone gate its use.
    always_ff @(posedge CLK) begin
        if (state_q == UPDATE) begin
            data_q[addr_q[IDX_W-1:0]] <= bus.mem_readdata;
            tag_q[addr_q[IDX_W-1:0]] <= addr_q[IDX_W +: TAG_W];
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: directed self-checking bench for instruction_cache.
module tb_instruction_cache;
    logic CLK = 1'b0;
    logic RESET;
    int n_checks = 0;
    int n_fail = 0;
    instruction_cache_if bus ();
    instruction_cache dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    always #5 CLK = ~CLK;

    function automatic logic [127:0] mk(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic miss_fill(input logic [31:0] a, input int lat, input logic [127:0] blk,
                             input logic [5:0] exp_ma, input logic [31:0] exp_w, input string nm);
        int busy = 0;
        @(posedge CLK); #1;
        bus.pc = a;
        bus.mem_readdata = blk;
        bus.mem_busywait = 1'b1;
        @(negedge CLK);
        busy += int'(bus.busywait);
        n_checks++;
        if ({bus.busywait, bus.mem_read} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s detect: busywait,mem_read=%b required 10", nm, {bus.busywait, bus.mem_read});
        end
        for (int k = 1; k <= lat; k++) begin
            @(posedge CLK); #1;
            bus.mem_busywait = k < lat;
            @(negedge CLK);
            busy += int'(bus.busywait);
            n_checks++;
            if ({bus.busywait, bus.mem_read, bus.mem_address} !== {2'b11, exp_ma}) begin
                n_fail++;
                $display("FAIL %s mem_read cycle %0d: busy,rd,addr=%b,%b,%b required 1,1,%b", nm, k,
                         bus.busywait, bus.mem_read, bus.mem_address, exp_ma);
            end
        end
        @(posedge CLK); #1;
        bus.mem_busywait = 1'b1;
        @(negedge CLK);
        busy += int'(bus.busywait);
        n_checks++;
        if ({bus.busywait, bus.mem_read} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s update: busywait,mem_read=%b required 10", nm, {bus.busywait, bus.mem_read});
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        busy += int'(bus.busywait);
        n_checks++;
        if ({bus.busywait, bus.mem_read, bus.instruction} !== {2'b00, exp_w}) begin
            n_fail++;
            $display("FAIL %s hit after fill: busy,rd,instr=%b,%b,%h required 0,0,%h", nm,
                     bus.busywait, bus.mem_read, bus.instruction, exp_w);
        end
        n_checks++;
        if (busy !== lat + 2) begin
            n_fail++;
            $display("FAIL %s miss penalty: %0d busy cycles required %0d", nm, busy, lat + 2);
        end
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] exp_w, input string nm);
        @(posedge CLK); #1;
        bus.pc = a;
        @(negedge CLK);
        n_checks++;
        if ({bus.busywait, bus.mem_read, bus.instruction} !== {2'b00, exp_w}) begin
            n_fail++;
            $display("FAIL %s: busy,rd,instr=%b,%b,%h required 0,0,%h", nm,
                     bus.busywait, bus.mem_read, bus.instruction, exp_w);
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        bus.pc = 32'hFFFF_FFFC;
        bus.mem_busywait = 1'b0;
        bus.mem_readdata = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({bus.busywait, bus.mem_read, bus.mem_address, bus.instruction} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset: busy,rd,addr,instr=%b,%b,%b,%h required all zero",
                     bus.busywait, bus.mem_read, bus.mem_address, bus.instruction);
        end
    endtask

    task automatic test_first_miss;
        miss_fill(32'h0, 5, mk(32'hA000_0000), 6'b000000, 32'hA000_0000, "first_miss");
    endtask

    task automatic test_sequential_hits;
        hit(32'h4, 32'hA000_0001, "hit_w1");
        hit(32'h8, 32'hA000_0002, "hit_w2");
        hit(32'hC, 32'hA000_0003, "hit_w3");
    endtask

    task automatic test_conflict;
        miss_fill(32'h80, 3, mk(32'hB000_0000), 6'b001000, 32'hB000_0000, "tag1_idx0");
        miss_fill(32'h0, 2, mk(32'hC000_0000), 6'b000000, 32'hC000_0000, "conflict_back");
    endtask

    task automatic test_independent_lines;
        miss_fill(32'h10, 2, mk(32'hD000_0000), 6'b000001, 32'hD000_0000, "idx1");
        miss_fill(32'h24, 2, mk(32'hE000_0000), 6'b000010, 32'hE000_0001, "idx2");
        hit(32'h14, 32'hD000_0001, "idx1_rehit");
        hit(32'h28, 32'hE000_0002, "idx2_rehit");
        hit(32'hC, 32'hC000_0003, "idx0_rehit");
    endtask

    task automatic test_reset_mid_fill;
        @(posedge CLK); #1;
        bus.pc = 32'h30;
        bus.mem_busywait = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++;
        if (bus.mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL midfill_setup: mem_read=%b required 1", bus.mem_read);
        end
        #2 RESET = 1'b1;
        bus.pc = 32'hFFFF_FFFC;
        #1;
        n_checks++;
        if ({bus.busywait, bus.mem_read, bus.mem_address} !== 8'h0) begin
            n_fail++;
            $display("FAIL midfill_abort: busy,rd,addr=%b,%b,%b required 0,0,000000",
                     bus.busywait, bus.mem_read, bus.mem_address);
        end
        @(posedge CLK); #1 RESET = 1'b0;
        miss_fill(32'h30, 4, mk(32'hF000_0000), 6'b000011, 32'hF000_0000, "refetch_after_reset");
    endtask

    task automatic test_zero_latency;
        miss_fill(32'h4, 1, mk(32'h1200_0000), 6'b000000, 32'h1200_0001, "zero_latency");
    endtask

    task automatic test_boot_pc;
        hit(32'hFFFF_FFFC, 32'h0, "boot_pc");
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_sequential_hits();
        test_conflict();
        test_independent_lines();
        test_reset_mid_fill();
        test_zero_latency();
        test_boot_pc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
